// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the elastic pipeline-stage registers.
// State encoding doubles as the occupancy count.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // Default bundle widths for each pipeline boundary
  localparam int IFID_CTRL_W  = 1;   // valid-instruction marker
  localparam int IFID_DATA_W  = 64;  // pc, instruction
  localparam int IDEX_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 79;  // rs1/rs2/rd indices, two operands
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 70;  // alu_result, write_data, rd, zero
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;  // read_data, alu_result, rd

  // Bit offsets inside the control bundle
  localparam int REGWRITE = 0;
  localparam int MEMTOREG = 1;
  localparam int MEMWRITE = 2;
  localparam int MEMREAD  = 3;

  function automatic logic [1:0] occupancy_of(input stage_state_t s);
    return logic'(s == ST_TWO) ? 2'd2 : ((s == ST_ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Latency 1 cycle from inc to count; no backpressure.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: ctrl/data bundles across valid/ready, optional 2-entry skid.
// Latency 1 cycle; in_ready registered with skid, combinational otherwise; flush kills everything held.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int DATA_W  = 79,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state_q, state_nxt;
  logic              main_vld_q;
  logic              rdy_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic in_xfer, out_xfer;
  logic ld_main_in, ld_main_skid, ld_skid, clr_main_ctrl, clr_skid;

  assign in_ready = (SKID_EN != 0) ? rdy_q : (!main_vld_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_vld_q && out_ready;

  // State register; valid and ready are kept as their own flops so the
  // outputs never pass through decode logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      main_vld_q <= (state_nxt != ST_EMPTY);
      rdy_q      <= (state_nxt != ST_TWO);
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_xfer && !out_xfer && (SKID_EN != 0)) state_nxt = ST_TWO;
          else if (!in_xfer && out_xfer)              state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (out_xfer) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    ld_main_in    = 1'b0;
    ld_main_skid  = 1'b0;
    ld_skid       = 1'b0;
    clr_main_ctrl = 1'b0;
    clr_skid      = 1'b0;
    if (flush) begin
      clr_main_ctrl = 1'b1;
      clr_skid      = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: ld_main_in = in_xfer;
        ST_ONE: begin
          if (in_xfer && out_xfer)                     ld_main_in    = 1'b1;
          else if (in_xfer && (SKID_EN != 0))          ld_skid       = 1'b1;
          else if (out_xfer)                           clr_main_ctrl = 1'b1;
        end
        ST_TWO: begin
          ld_main_skid = out_xfer;
          clr_skid     = out_xfer;
        end
        default: clr_main_ctrl = 1'b1;
      endcase
    end
  end

  // Data stays put on a bubble; only the control bundle is zeroed so a
  // downstream stage sees a harmless NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (ld_main_in) begin
      main_ctrl_q <= in_ctrl;
      main_data_q <= in_data;
    end else if (ld_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end else if (clr_main_ctrl) begin
      main_ctrl_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_skid) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (ld_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end

  assign out_valid = main_vld_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_of(state_q);

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_vld_q && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, no-skid and narrow-counter instances share one stimulus.
module tb_pipe_stage_reg;
  localparam int CW = 4;
  localparam int DW = 79;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          n_in_ready, n_out_valid;
  logic [CW-1:0] n_out_ctrl;
  logic [DW-1:0] n_out_data;
  logic [1:0]    n_occupancy;
  logic [15:0]   n_stall_cnt;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occupancy;
  logic [3:0]    c_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [CW+DW-1:0] q_s[$];
  logic [CW+DW-1:0] q_n[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(0), .CNT_W(16)) dut_n (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_ctrl(n_out_ctrl), .out_data(n_out_data), .occupancy(n_occupancy), .stall_cnt(n_stall_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occupancy), .stall_cnt(c_stall_cnt));

  // Scoreboards: push on accepted input, pop on delivered output, wiped by flush/reset.
  always begin
    logic [CW+DW-1:0] exp;
    @(negedge clk); #2;
    if (reset) q_s.delete();
    else begin
      if (out_valid && out_ready) begin
        total++;
        if (q_s.size() == 0) begin
          bad++; $display("FAIL sb_skid_unexpected: got %h expected none", {out_ctrl, out_data});
        end else begin
          exp = q_s.pop_front();
          if ({out_ctrl, out_data} !== exp) begin
            bad++; $display("FAIL sb_skid_order: got %h expected %h", {out_ctrl, out_data}, exp);
          end
        end
      end
      if (flush) q_s.delete();
      else if (in_valid && in_ready) q_s.push_back({in_ctrl, in_data});
    end
  end

  always begin
    logic [CW+DW-1:0] exp;
    @(negedge clk); #2;
    if (reset) q_n.delete();
    else begin
      if (n_out_valid && out_ready) begin
        total++;
        if (q_n.size() == 0) begin
          bad++; $display("FAIL sb_noskid_unexpected: got %h expected none", {n_out_ctrl, n_out_data});
        end else begin
          exp = q_n.pop_front();
          if ({n_out_ctrl, n_out_data} !== exp) begin
            bad++; $display("FAIL sb_noskid_order: got %h expected %h", {n_out_ctrl, n_out_data}, exp);
          end
        end
      end
      if (flush) q_n.delete();
      else if (in_valid && n_in_ready) q_n.push_back({in_ctrl, in_data});
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1} || out_data !== '0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_state: got v=%b c=%h d=%h occ=%0d st=%0d rdy=%b expected 0 0 0 0 0 1",
                      out_valid, out_ctrl, out_data, occupancy, stall_cnt, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] vals[3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_ctrl = 4'b0110; in_data = DW'(vals[i]);
      if (i == 2) begin
        total++;
        if (occupancy !== 2'd2) begin bad++; $display("FAIL mid_occ: got %0d expected 2", occupancy); end
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1} || out_data !== '0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_reset: got v=%b c=%h d=%h occ=%0d st=%0d rdy=%b expected 0 0 0 0 0 1",
                      out_valid, out_ctrl, out_data, occupancy, stall_cnt, in_ready);
    end
  endtask

  task automatic test_throughput();
    int cnt_s = 0;
    int cnt_n = 0;
    out_ready = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid)   cnt_s++;
      if (n_out_valid) cnt_n++;
      if (k == 1) begin
        total++;
        if (!out_valid || out_data !== DW'(1) || !n_out_valid || n_out_data !== DW'(1)) begin
          bad++; $display("FAIL tp_latency: got skid v=%b d=%0d noskid v=%b d=%0d expected 1 1 1 1",
                          out_valid, out_data, n_out_valid, n_out_data);
        end
      end
      in_valid = (k < 100); in_ctrl = 4'b1011; in_data = DW'(k + 1);
    end
    @(negedge clk);
    total++;
    if (cnt_s != 100) begin bad++; $display("FAIL tp_skid_count: got %0d expected 100", cnt_s); end
    total++;
    if (cnt_n != 100) begin bad++; $display("FAIL tp_noskid_count: got %0d expected 100", cnt_n); end
    total++;
    if (out_valid || n_out_valid || n_occupancy !== 2'd0) begin
      bad++; $display("FAIL tp_drain: got v=%b nv=%b nocc=%0d expected 0 0 0", out_valid, n_out_valid, n_occupancy);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'b0101; in_data = DW'(8'hA);
    @(negedge clk);
    in_data = DW'(8'hB);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full: got occ=%0d rdy=%b expected 2 0", occupancy, in_ready);
    end
    repeat (5) @(negedge clk);
    total++;
    if (stall_cnt !== 16'd6 || out_data !== DW'(8'hA)) begin
      bad++; $display("FAIL bp_stall: got st=%0d d=%h expected 6 a", stall_cnt, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_data !== DW'(8'hB) || occupancy !== 2'd1) begin
      bad++; $display("FAIL bp_release: got rdy=%b d=%h occ=%0d expected 1 b 1", in_ready, out_data, occupancy);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd6) begin
      bad++; $display("FAIL bp_drain: got v=%b st=%0d expected 0 6", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'b0101; in_data = DW'(8'hA);
    @(negedge clk);
    in_data = DW'(8'hB);
    @(negedge clk);
    total++;
    if (occupancy !== 2'd2) begin bad++; $display("FAIL fl_occ: got %0d expected 2", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_data = DW'(8'hC);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1} || out_data !== DW'(8'hA)) begin
      bad++; $display("FAIL fl_state: got v=%b c=%h occ=%0d rdy=%b d=%h expected 0 0 0 1 a",
                      out_valid, out_ctrl, occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_ghost: got v=%b d=%h expected 0", out_valid, out_data); end
    end
  endtask

  task automatic test_bubble();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 4'b1111; in_data = DW'(8'h5A);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 4'b1111) begin
      bad++; $display("FAIL bub_present: got v=%b c=%b expected 1 1111", out_valid, out_ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 4'b0000 || out_data !== DW'(8'h5A)) begin
        bad++; $display("FAIL bub_nop: got v=%b c=%b d=%h expected 0 0000 5a", out_valid, out_ctrl, out_data);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'b0001; in_data = DW'(8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (c_stall_cnt !== 4'd0 || c_out_valid !== 1'b1) begin
      bad++; $display("FAIL sat_start: got st=%0d v=%b expected 0 1", c_stall_cnt, c_out_valid);
    end
    repeat (20) @(negedge clk);
    total++;
    if (c_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      bad++; $display("FAIL sat_cap: got narrow=%0d wide=%0d expected 15 20", c_stall_cnt, stall_cnt);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (c_stall_cnt !== 4'd15 || stall_cnt !== 16'd21 || c_out_valid !== 1'b0) begin
      bad++; $display("FAIL sat_flush: got narrow=%0d wide=%0d v=%b expected 15 21 0", c_stall_cnt, stall_cnt, c_out_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (c_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL sat_reset: got narrow=%0d wide=%0d expected 0 0", c_stall_cnt, stall_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    test_reset();
    test_reset_midstream();
    test_throughput();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle across a valid/ready handshake, with optional 2-entry skid buffering, synchronous flush and a saturating stall counter.
- Control bits are forced to zero whenever the stage holds no valid entry, so a bubble is always a safe NOP.
- Replaces the fixed-field stage registers.

Parameters:
CTRL_W, 4, width of control bundle (RegWrite/MemtoReg/MemWrite/MemRead style bits); zeroed on bubble, flush, reset.
DATA_W, 79, width of data bundle (e.g. rs1/rs2/rd, alu_result, write_data, zero flag).
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous kill of all held entries and of any same-cycle input.
in_valid  input  1  upstream holds a valid entry.
in_ready  output  1  stage accepts an entry this cycle.
in_ctrl  input  CTRL_W  upstream control bundle.
in_data  input  DATA_W  upstream data bundle.
out_valid  output  1  stage presents a valid entry.
out_ready  input  1  downstream accepts this cycle.
out_ctrl  output  CTRL_W  control bundle; all zero when out_valid=0.
out_data  output  DATA_W  data bundle; holds last value when out_valid=0.
occupancy  output  2  number of held entries (0..2).
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
Handshakes
- Input transfer = in_valid & in_ready.
- Output transfer = out_valid & out_ready.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush.
- out_valid, out_ctrl and out_data come directly from the main register, not from combinational paths.

Reset
- out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, skid register cleared.
- in_ready=1 after reset (SKID_EN=1).
- Reset has priority over flush and all transfers.

States (SKID_EN=1): EMPTY, ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO), registered.
- EMPTY: input transfer -> ONE, main <= input.
- ONE, input only -> TWO, skid <= input.
- ONE, output only -> EMPTY.
- ONE, both -> ONE, main <= input.
- ONE, neither -> ONE, hold.
- TWO: input impossible (in_ready=0).
- TWO, output transfer -> ONE, main <= skid.
- TWO, no output transfer -> hold.

SKID_EN=0
- States EMPTY and ONE only.
- in_ready = !out_valid | out_ready (combinational).
- Simultaneous in/out transfer replaces main in one cycle. Zero bubbles at full throughput.

Latency and throughput
- Input to out_valid: 1 cycle.
- Full throughput of 1 entry/cycle in both modes.

Flush (synchronous)
- Next state EMPTY; out_valid=0; out_ctrl=0; skid cleared.
- Any same-cycle input transfer is discarded. Flush has priority over input.
- out_data is not cleared.
- A same-cycle output transfer of the current entry still counts as delivered downstream.

Stall counter
- Increments by 1 on each cycle with out_valid & !out_ready.
- Saturates at 2^CNT_W-1.
- Unaffected by flush; cleared only by reset.

occupancy: 0/1/2 for EMPTY/ONE/TWO; never 2 when SKID_EN=0.

Upstream rule: changing in_ctrl/in_data while in_valid=1 and in_ready=0 is legal. The entry is sampled only on the transfer cycle.

Decomposition:
Shared package:
- State encoding for EMPTY/ONE/TWO (2-bit).
- Localparam default widths for each pipeline boundary: IFID, IDEX, EXMEM, MEMWB DATA_W/CTRL_W.
- Named bit offsets of the control bundle: REGWRITE, MEMTOREG, MEMWRITE, MEMREAD.

Sub-module: pipe_sat_counter (CNT_W, increment enable, synchronous reset, saturate). Everything else stays in pipe_stage_reg.

Test Plan:
1. Reset mid-stream: 3 entries in flight (data 0x11, 0x22, 0x33), assert reset 1 cycle -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0 next cycle; in_ready=1.
2. Full throughput, SKID_EN=0 and 1: stream data 1..100 with out_ready=1, ctrl=4'b1011 -> outputs 1..100 in order, 1-cycle latency, no gaps.
3. Backpressure (SKID_EN=1): send 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle. Hold 5 cycles -> stall_cnt=6. Release -> 0xA then 0xB in order, in_ready=1 after 0xA leaves.
4. Flush with simultaneous input: occupancy=2 holding 0xA, 0xB; assert flush with in_valid=1, data 0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xC never appears at the output.
5. Bubble control: ctrl=4'b1111 entry consumed, no new input -> out_valid=0 and out_ctrl=4'b0000 while out_data holds the last value.
6. Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Flush -> still 15. Reset -> 0.
